cpu_mem_responder: RTL

//  Memory-side responder for the softcore's RAM port (address/data/rden/wren/q).

---
 rtl/cpu_mem_responder_if.sv | 29 ++
 rtl/cpu_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// ============================================================================
// cpu_mem_responder_if : core RAM port plus LED and TX-sink signals
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cpu_mem_responder_if;
    logic [15:0] address;
    logic [7:0]  data;
    logic        rden;
    logic        wren;
    logic [7:0]  q;
    logic [7:0]  led_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output address, data, rden, wren, tx_ready,
        input  q, led_out, tx_valid, tx_data
    );

    modport slave (
        input  address, data, rden, wren, tx_ready,
        output q, led_out, tx_valid, tx_data
    );
endinterface

`default_nettype wire

// File: rtl/cpu_mem_responder.sv
// ============================================================================
// cpu_mem_responder : 2-cycle-latency RAM plus I/O page (LED, TX FIFO, timer)
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_mem_responder #(
    parameter int          RAM_DEPTH  = 16384,
    parameter logic [15:0] IO_BASE    = 16'hF000,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_mem_responder_if.slave bus
);

    localparam int         c_AW      = $clog2(RAM_DEPTH);
    localparam int         c_PW      = $clog2(FIFO_DEPTH);
    localparam int         c_CW      = c_PW + 1;
    localparam logic [3:0] c_OFF_LED = 4'h0;
    localparam logic [3:0] c_OFF_TX  = 4'h1;
    localparam logic [3:0] c_OFF_ST  = 4'h2;
    localparam logic [3:0] c_OFF_TLO = 4'h3;
    localparam logic [3:0] c_OFF_THI = 4'h4;

    logic [7:0]      r_mem [RAM_DEPTH];
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic [7:0]      r_led;
    logic [15:0]     r_timer;
    logic [7:0]      r_shadow;
    logic            r_rd_valid;
    logic [15:0]     r_rd_addr;
    logic [7:0]      r_q;

    // Write-side decode; RAM takes precedence if the I/O page overlaps it.
    logic w_wr_ram, w_wr_io, w_led_wr, w_push;
    assign w_wr_ram = (bus.address[15:c_AW] == '0);
    assign w_wr_io  = !w_wr_ram && (bus.address[15:4] == IO_BASE[15:4]);
    assign w_led_wr = bus.wren && w_wr_io && (bus.address[3:0] == c_OFF_LED);
    assign w_push   = bus.wren && w_wr_io && (bus.address[3:0] == c_OFF_TX);

    // Stage-2 decode of the registered read address.
    logic w_rd_ram, w_rd_io, w_rd_status, w_rd_tlo;
    assign w_rd_ram    = (r_rd_addr[15:c_AW] == '0);
    assign w_rd_io     = !w_rd_ram && (r_rd_addr[15:4] == IO_BASE[15:4]);
    assign w_rd_status = r_rd_valid && w_rd_io && (r_rd_addr[3:0] == c_OFF_ST);
    assign w_rd_tlo    = r_rd_valid && w_rd_io && (r_rd_addr[3:0] == c_OFF_TLO);

    logic w_full, w_empty, w_pop, w_push_ok;
    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && bus.tx_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    logic [7:0] w_rd_data;
    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_ram) begin
            w_rd_data = r_mem[r_rd_addr[c_AW-1:0]];
        end else if (w_rd_io) begin
            case (r_rd_addr[3:0])
                c_OFF_LED: w_rd_data = r_led;
                c_OFF_ST:  w_rd_data = {5'b0, r_ovf, w_full, w_empty};
                c_OFF_TLO: w_rd_data = r_timer[7:0];
                c_OFF_THI: w_rd_data = r_shadow;
                default:   w_rd_data = 8'h00;
            endcase
        end
    end

    // Storage arrays carry no reset so RAM contents survive it.
    always_ff @(posedge clk) begin
        if (bus.wren && w_wr_ram) begin
            r_mem[bus.address[c_AW-1:0]] <= bus.data;
        end
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_q        <= '0;
        end else begin
            r_rd_valid <= bus.rden && !bus.wren;
            r_rd_addr  <= bus.address;
            if (r_rd_valid) begin
                r_q <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led    <= '0;
            r_timer  <= '0;
            r_shadow <= '0;
        end else begin
            r_timer <= r_timer + 16'd1;
            if (w_led_wr) begin
                r_led <= bus.data;
            end
            if (w_rd_tlo) begin
                r_shadow <= r_timer[15:8];
            end
        end
    end

    // A dropped push in the same edge as a STATUS read keeps overflow set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_rd_status) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.q        = r_q;
    assign bus.led_out  = r_led;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

endmodule

`default_nettype wire
